// File: rtl/exec_pc_datapath.sv
// Execute-stage datapath: 16-bit scalar ALU with NZCV flags, 8x8-bit SIMD lane unit
// with halfword histogram increment, and an enable-gated program-counter register.
module exec_pc_datapath #(
   parameter logic [15:0] PC_RESET = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] pc_in,
   output logic [15:0] pc,
   input  logic [15:0] alu_a,
   input  logic [15:0] alu_b,
   input  logic [2:0]  alu_control,
   output logic [15:0] alu_result,
   output logic [3:0]  alu_flags,
   input  logic [2:0]  lane_control,
   input  logic [63:0] lanes_in,
   input  logic [15:0] lane_src_b,
   input  logic [1:0]  lane_sel,
   output logic [63:0] lanes_result
);

   localparam logic [2:0] LANE_HINC = 3'b110;

   logic [15:0] pc_reg;
   logic [16:0] add_full;
   logic [16:0] sub_full;
   logic        carry_next;
   logic        ovf_next;
   logic [15:0] result_next;
   logic [7:0]  b8;
   logic [63:0] byte_result;
   logic [63:0] hinc_result;
   logic        unused_src_b_high;

   // ---------------- Program counter ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg <= PC_RESET;
      end else if (enable) begin
         pc_reg <= pc_in;
      end
   end

   assign pc = pc_reg;

   // ---------------- Scalar ALU ----------------
   assign add_full = {1'b0, alu_a} + {1'b0, alu_b};
   assign sub_full = {1'b0, alu_a} - {1'b0, alu_b};

   always_comb begin
      result_next = 16'h0000;
      carry_next  = 1'b0;
      ovf_next    = 1'b0;
      case (alu_control)
         3'b000: begin
            result_next = add_full[15:0];
            carry_next  = add_full[16];
            ovf_next    = (alu_a[15] == alu_b[15]) && (add_full[15] != alu_a[15]);
         end
         3'b001: begin
            // Bit 16 of the widened difference is the borrow; carry is its inverse.
            result_next = sub_full[15:0];
            carry_next  = ~sub_full[16];
            ovf_next    = (alu_a[15] != alu_b[15]) && (sub_full[15] != alu_a[15]);
         end
         3'b010:  result_next = alu_a & alu_b;
         3'b011:  result_next = alu_a | alu_b;
         3'b100:  result_next = alu_a ^ alu_b;
         3'b101:  result_next = alu_a << alu_b[3:0];
         3'b110:  result_next = alu_a >> alu_b[3:0];
         default: result_next = alu_b;
      endcase
   end

   assign alu_result = result_next;
   assign alu_flags  = {result_next[15], (result_next == 16'h0000), carry_next, ovf_next};

   // ---------------- SIMD lanes ----------------
   assign b8 = lane_src_b[7:0];
   assign unused_src_b_high = &{1'b0, lane_src_b[15:8]};

   function automatic logic [7:0] lane_op(input logic [7:0] x, input logic [7:0] b,
                                          input logic [2:0] op);
      logic [8:0] wide_sum;
      logic [8:0] wide_diff;
      logic [7:0] r;
      wide_sum  = {1'b0, x} + {1'b0, b};
      wide_diff = {1'b0, x} - {1'b0, b};
      r = x;
      case (op)
         3'b000:  r = wide_sum[7:0];
         3'b001:  r = wide_diff[7:0];
         3'b010:  r = wide_sum[8] ? 8'hFF : wide_sum[7:0];
         3'b011:  r = wide_diff[8] ? 8'h00 : wide_diff[7:0];
         3'b100:  r = x >> b[2:0];
         3'b101:  r = x << b[2:0];
         default: r = x;
      endcase
      return r;
   endfunction

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_byte_lane
         assign byte_result[8*gi +: 8] = lane_op(lanes_in[8*gi +: 8], b8, lane_control);
      end

      // Histogram bins: only the selected halfword increments, saturating at all-ones.
      for (genvar gi = 0; gi < 4; gi++) begin : g_hinc_bin
         assign hinc_result[16*gi +: 16] =
            ((lane_sel == gi[1:0]) && (lanes_in[16*gi +: 16] != 16'hFFFF))
               ? lanes_in[16*gi +: 16] + 16'h0001
               : lanes_in[16*gi +: 16];
      end
   endgenerate

   assign lanes_result = (lane_control == LANE_HINC) ? hinc_result : byte_result;

endmodule

// File: tb/tb_exec_pc_datapath.sv
// Self-checking bench for exec_pc_datapath: integer-arithmetic reference model checked
// every cycle, plus literal expectations for the documented example vectors.
module tb_exec_pc_datapath;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] pc_in;
   logic [15:0] pc;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [2:0]  alu_control;
   logic [15:0] alu_result;
   logic [3:0]  alu_flags;
   logic [2:0]  lane_control;
   logic [63:0] lanes_in;
   logic [15:0] lane_src_b;
   logic [1:0]  lane_sel;
   logic [63:0] lanes_result;

   int checks = 0;
   int passes = 0;
   bit run = 1'b0;
   bit pc_known = 1'b0;
   logic [15:0] exp_pc = 16'h0000;

   exec_pc_datapath #(.PC_RESET(16'h0000)) dut (
      .clk(clk), .reset(reset), .enable(enable), .pc_in(pc_in), .pc(pc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .lane_control(lane_control), .lanes_in(lanes_in), .lane_src_b(lane_src_b),
      .lane_sel(lane_sel), .lanes_result(lanes_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %h required %h", name, got, exp);
   endtask

   // Reference scalar ALU from plain integer arithmetic; returns {N,Z,C,V,result}.
   function automatic logic [19:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [2:0] op);
      int ua, ub, sa, sb, full, sr;
      logic [15:0] res;
      bit c, v;
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      c = 0; v = 0;
      case (op)
         3'd0: begin full = ua + ub; c = (full > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
         3'd1: begin full = ua - ub; c = (ua >= ub);     sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
         3'd2: full = ua & ub;
         3'd3: full = ua | ub;
         3'd4: full = ua ^ ub;
         3'd5: full = ua * (1 << (ub % 16));
         3'd6: full = ua / (1 << (ub % 16));
         default: full = ub;
      endcase
      res = full[15:0];
      return {res[15], (res == 16'h0000), c, v, res};
   endfunction

   function automatic logic [63:0] lane_model(input logic [63:0] vin, input logic [15:0] src,
                                              input logic [1:0] sel, input logic [2:0] op);
      logic [63:0] r;
      int x, b, y, h;
      b = src % 256;
      r = vin;
      if (op == 3'd6) begin
         for (int j = 0; j < 4; j++) begin
            h = vin[16*j +: 16];
            if (j == sel && h < 65535) h = h + 1;
            r[16*j +: 16] = h[15:0];
         end
      end else if (op != 3'd7) begin
         for (int k = 0; k < 8; k++) begin
            x = vin[8*k +: 8];
            case (op)
               3'd0: y = (x + b) % 256;
               3'd1: y = (x - b + 256) % 256;
               3'd2: y = (x + b > 255) ? 255 : x + b;
               3'd3: y = (x - b < 0) ? 0 : x - b;
               3'd4: y = x / (1 << (b % 8));
               default: y = (x * (1 << (b % 8))) % 256;
            endcase
            r[8*k +: 8] = y[7:0];
         end
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         exp_pc   <= 16'h0000;
         pc_known <= 1'b1;
      end else if (enable) begin
         exp_pc <= pc_in;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      logic [19:0] ea;
      if (run) begin
         ea = alu_model(alu_a, alu_b, alu_control);
         check("model_alu_result", {48'd0, alu_result}, {48'd0, ea[15:0]});
         check("model_alu_flags", {60'd0, alu_flags}, {60'd0, ea[19:16]});
         check("model_lanes", lanes_result, lane_model(lanes_in, lane_src_b, lane_sel, lane_control));
         if (pc_known) check("model_pc", {48'd0, pc}, {48'd0, exp_pc});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      tick();
      alu_control = op; alu_a = a; alu_b = b;
      @(negedge clk);
   endtask

   task automatic set_lane(input logic [2:0] op, input logic [63:0] v, input logic [15:0] b,
                           input logic [1:0] sel);
      tick();
      lane_control = op; lanes_in = v; lane_src_b = b; lane_sel = sel;
      @(negedge clk);
   endtask

   localparam logic [63:0] VEC4 = 64'hF0_10_FF_00_80_7F_01_FE;
   localparam logic [63:0] HVEC = 64'h0001_FFFF_0000_1234;

   initial begin
      logic [15:0] ops_a [6];
      logic [15:0] ops_b [6];
      logic [63:0] vecs  [4];
      logic [15:0] lbs   [4];
      ops_a = '{16'h7FFF, 16'hFFFF, 16'h8000, 16'h1234, 16'h0003, 16'hA5A5};
      ops_b = '{16'h0001, 16'h0001, 16'h8000, 16'hFF13, 16'h0005, 16'h5A5A};
      vecs  = '{VEC4, HVEC, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF};
      lbs   = '{16'h0010, 16'hAB07, 16'h00FF, 16'h0003};

      reset = 1'b1; enable = 1'b1; pc_in = 16'h0040;
      alu_a = '0; alu_b = '0; alu_control = '0;
      lane_control = '0; lanes_in = '0; lane_src_b = '0; lane_sel = '0;
      run = 1'b1;

      tick(); @(negedge clk);
      check("reset_pc", {48'd0, pc}, 64'h0000);
      tick(); reset = 1'b0;
      tick(); @(negedge clk);
      check("load_pc", {48'd0, pc}, 64'h0040);
      tick(); enable = 1'b0; pc_in = 16'h0044;
      tick(); @(negedge clk);
      check("stall_pc", {48'd0, pc}, 64'h0040);
      tick(); reset = 1'b1;
      tick(); @(negedge clk);
      check("reset_while_stalled", {48'd0, pc}, 64'h0000);
      tick(); reset = 1'b0; enable = 1'b1; pc_in = 16'hBEEF;
      tick(); @(negedge clk);
      check("load_pc2", {48'd0, pc}, 64'hBEEF);

      set_alu(3'd0, 16'h7FFF, 16'h0001);
      check("add_ovf_res", {48'd0, alu_result}, 64'h8000);
      check("add_ovf_flags", {60'd0, alu_flags}, 64'h9);
      set_alu(3'd0, 16'hFFFF, 16'h0001);
      check("add_carry_res", {48'd0, alu_result}, 64'h0000);
      check("add_carry_flags", {60'd0, alu_flags}, 64'h6);
      set_alu(3'd1, 16'h0003, 16'h0005);
      check("sub_borrow_res", {48'd0, alu_result}, 64'hFFFE);
      check("sub_borrow_flags", {60'd0, alu_flags}, 64'h8);
      set_alu(3'd1, 16'h0005, 16'h0005);
      check("sub_eq_flags", {60'd0, alu_flags}, 64'h6);
      set_alu(3'd5, 16'h0001, 16'h000F);
      check("shl15", {48'd0, alu_result}, 64'h8000);
      set_alu(3'd6, 16'h8000, 16'h00F3);
      check("shr3", {48'd0, alu_result}, 64'h1000);
      set_alu(3'd7, 16'hFFFF, 16'h1234);
      check("pass_b", {48'd0, alu_result}, 64'h1234);

      for (int op = 0; op < 8; op++)
         for (int i = 0; i < 6; i++)
            set_alu(op[2:0], ops_a[i], ops_b[i]);

      set_lane(3'd2, VEC4, 16'h0010, 2'd0);
      check("vadds", lanes_result, 64'hFF_20_FF_10_90_8F_11_FF);
      set_lane(3'd0, VEC4, 16'h0010, 2'd0);
      check("vadd_wrap", lanes_result, 64'h00_20_0F_10_90_8F_11_0E);
      set_lane(3'd3, 64'h0505_0505_0505_0505, 16'hFF08, 2'd0);
      check("vsubs_sat", lanes_result, 64'h0);
      set_lane(3'd4, 64'h8080_8080_8080_8080, 16'h0003, 2'd0);
      check("vshr", lanes_result, 64'h1010_1010_1010_1010);
      set_lane(3'd6, HVEC, 16'h0000, 2'd2);
      check("hinc_sat", lanes_result, HVEC);
      set_lane(3'd6, HVEC, 16'h0000, 2'd0);
      check("hinc_bin0", lanes_result, 64'h0001_FFFF_0000_1235);
      set_lane(3'd6, HVEC, 16'h0000, 2'd3);
      check("hinc_bin3", lanes_result, 64'h0002_FFFF_0000_1234);

      for (int op = 0; op < 8; op++)
         for (int i = 0; i < 4; i++)
            set_lane(op[2:0], vecs[i], lbs[i], i[1:0]);

      tick();
      run = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
